// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Width of an occupancy count that must reach the full depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register array: synchronous write, combinational read.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // NOTE: storage is deliberately not reset; the pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, error pulses and a
// selectable standard or first-word-fall-through read port.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         FIFO_DEPTH = 16,
    parameter int         ALMOST_WR  = 2,
    parameter int         ALMOST_RD  = 1,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                din,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic                                 full,
    output logic                                 almost_full,
    output logic                                 empty,
    output logic                                 almost_empty,
    output logic                                 wr_ack,
    output logic                                 overflow,
    output logic                                 valid,
    output logic                                 underflow,
    output logic [count_width(FIFO_DEPTH)-1:0]   data_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = count_width(FIFO_DEPTH);

    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(FIFO_DEPTH - ALMOST_WR);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(ALMOST_RD);

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
    end
    if (ALMOST_WR >= FIFO_DEPTH) begin : g_bad_almost_wr
        $fatal(1, "sync_fifo: ALMOST_WR must be below FIFO_DEPTH");
    end
    if (ALMOST_RD >= FIFO_DEPTH) begin : g_bad_almost_rd
        $fatal(1, "sync_fifo: ALMOST_RD must be below FIFO_DEPTH");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, almost_full_q, almost_full_d;
    logic                  empty_q, empty_d, almost_empty_q, almost_empty_d;
    logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d;
    logic                  underflow_q, underflow_d, valid_q, valid_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wr_accept, rd_accept;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (din),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // NOTE: every always_comb output is given a value on every path, so no latch is inferred.
    always_comb begin
        wr_accept = wr_en && !full_q;
        rd_accept = rd_en && !empty_q;

        wr_ptr_d = wr_ptr_q + PW'(wr_accept);
        rd_ptr_d = rd_ptr_q + PW'(rd_accept);
        count_d  = wr_ptr_d - rd_ptr_d;

        full_d         = (count_d == FULL_LEVEL);
        almost_full_d  = (count_d >= AF_LEVEL);
        empty_d        = (count_d == '0);
        almost_empty_d = (count_d <= AE_LEVEL);

        wr_ack_d    = wr_accept;
        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;
        valid_d     = rd_accept;

        dout_d = dout_q;
        if (MODE == FIFO_STD && rd_accept) begin
            dout_d = ram_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            wr_ack_q       <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            valid_q        <= 1'b0;
            dout_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            wr_ack_q       <= wr_ack_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            valid_q        <= valid_d;
            dout_q         <= dout_d;
        end
    end

    // FWFT presents the head word straight from the array, forced to zero when nothing is stored.
    assign dout  = (MODE == FIFO_FWFT) ? (empty_q ? '0 : ram_rdata) : dout_q;
    assign valid = (MODE == FIFO_FWFT) ? !empty_q : valid_q;

    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign wr_ack       = wr_ack_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign data_count   = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: one STD and one FWFT instance, depth 8, scoreboard-driven.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst = 1'b1, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0] s_din = 8'h00, s_dout;
    logic       s_full, s_almost_full, s_empty, s_almost_empty;
    logic       s_wr_ack, s_overflow, s_valid, s_underflow;
    logic [3:0] s_count;

    logic       f_rst = 1'b1, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_din = 8'h00, f_dout;
    logic       f_full, f_almost_full, f_empty, f_almost_empty;
    logic       f_wr_ack, f_overflow, f_valid, f_underflow;
    logic [3:0] f_count;

    logic [7:0] s_flags, f_flags;
    assign s_flags = {s_full, s_almost_full, s_empty, s_almost_empty,
                      s_wr_ack, s_overflow, s_valid, s_underflow};
    assign f_flags = {f_full, f_almost_full, f_empty, f_almost_empty,
                      f_wr_ack, f_overflow, f_valid, f_underflow};

    sync_fifo #(
        .DATA_WIDTH (8), .FIFO_DEPTH (8), .ALMOST_WR (2), .ALMOST_RD (1), .MODE (FIFO_STD)
    ) u_std (
        .clk (clk), .rst (s_rst), .wr_en (s_wr_en), .din (s_din), .rd_en (s_rd_en),
        .dout (s_dout), .full (s_full), .almost_full (s_almost_full), .empty (s_empty),
        .almost_empty (s_almost_empty), .wr_ack (s_wr_ack), .overflow (s_overflow),
        .valid (s_valid), .underflow (s_underflow), .data_count (s_count)
    );

    sync_fifo #(
        .DATA_WIDTH (8), .FIFO_DEPTH (8), .ALMOST_WR (2), .ALMOST_RD (1), .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk (clk), .rst (f_rst), .wr_en (f_wr_en), .din (f_din), .rd_en (f_rd_en),
        .dout (f_dout), .full (f_full), .almost_full (f_almost_full), .empty (f_empty),
        .almost_empty (f_almost_empty), .wr_ack (f_wr_ack), .overflow (f_overflow),
        .valid (f_valid), .underflow (f_underflow), .data_count (f_count)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model for the STD instance.
    logic [7:0] sb [$];
    logic [3:0] m_count;
    logic [7:0] exp_dout;
    logic [7:0] exp_flags;

    task automatic model_std_reset();
        sb.delete();
        m_count   = 4'd0;
        exp_dout  = 8'h00;
        exp_flags = 8'b0011_0000;
    endtask

    task automatic model_std(input logic wr, input logic rd, input logic [7:0] d);
        logic wa, ra;
        wa = wr && (m_count != 4'd8);
        ra = rd && (m_count != 4'd0);
        if (ra) exp_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        m_count   = m_count + 4'(wa) - 4'(ra);
        exp_flags = {m_count == 4'd8, m_count >= 4'd6, m_count == 4'd0, m_count <= 4'd1,
                     wa, wr && !wa, ra, rd && !ra};
    endtask

    task automatic std_cycle(input logic wr, input logic rd, input logic [7:0] d);
        s_wr_en = wr;
        s_rd_en = rd;
        s_din   = d;
        @(posedge clk);
        #1;
        model_std(wr, rd, d);
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        s_rst   = 1'b1;
        f_rst   = 1'b1;
        s_wr_en = 1'b1;
        f_wr_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_rst   = 1'b0;
        f_rst   = 1'b0;
        s_wr_en = 1'b0;
        f_wr_en = 1'b0;
        model_std_reset();
        tests_run++;
        if (s_flags !== exp_flags || s_count !== 4'd0 || s_dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL std_reset: flags=%b count=%0d dout=%h, expected flags=%b count=0 dout=00",
                     s_flags, s_count, s_dout, exp_flags);
        end
        tests_run++;
        if (f_flags !== 8'b0011_0000 || f_count !== 4'd0 || f_dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL fwft_reset: flags=%b count=%0d dout=%h, expected flags=00110000 count=0 dout=00",
                     f_flags, f_count, f_dout);
        end
    endtask

    task automatic test_std_fill();
        logic [7:0] vals [9];
        vals = '{8'd17, 8'd20, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        for (int i = 0; i < 9; i++) begin
            std_cycle(1'b1, 1'b0, vals[i]);
            tests_run++;
            if (s_flags !== exp_flags || s_count !== m_count) begin
                tests_failed++;
                $display("FAIL std_fill[%0d]: flags=%b count=%0d, expected flags=%b count=%0d",
                         i + 1, s_flags, s_count, exp_flags, m_count);
            end
        end
    endtask

    task automatic test_std_drain();
        for (int i = 0; i < 10; i++) begin
            std_cycle(1'b0, 1'b1, 8'h00);
            tests_run++;
            if (s_flags !== exp_flags || s_count !== m_count || s_dout !== exp_dout) begin
                tests_failed++;
                $display("FAIL std_drain[%0d]: flags=%b count=%0d dout=%0d, expected flags=%b count=%0d dout=%0d",
                         i + 1, s_flags, s_count, s_dout, exp_flags, m_count, exp_dout);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            std_cycle(1'b1, 1'b0, 8'(8'h30 + i));
        end
        tests_run++;
        if (s_full !== 1'b1 || s_count !== 4'd8) begin
            tests_failed++;
            $display("FAIL simul_prefill: full=%b count=%0d, expected full=1 count=8", s_full, s_count);
        end
        std_cycle(1'b1, 1'b1, 8'hAA);
        tests_run++;
        if (s_flags !== exp_flags || s_count !== m_count || s_dout !== exp_dout) begin
            tests_failed++;
            $display("FAIL simul_full: flags=%b count=%0d dout=%h, expected flags=%b count=%0d dout=%h",
                     s_flags, s_count, s_dout, exp_flags, m_count, exp_dout);
        end
    endtask

    task automatic test_wrap_random();
        for (int i = 0; i < 40; i++) begin
            std_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            tests_run++;
            if (s_flags !== exp_flags || s_count !== m_count || s_dout !== exp_dout) begin
                tests_failed++;
                $display("FAIL wrap_random[%0d]: flags=%b count=%0d dout=%h, expected flags=%b count=%0d dout=%h",
                         i, s_flags, s_count, s_dout, exp_flags, m_count, exp_dout);
            end
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       rst;
        logic [7:0] din;
        logic [7:0] flags;
        logic [3:0] count;
        logic [7:0] dout;
    } fwft_step_t;

    task automatic test_fwft_reset_mid_op();
        fwft_step_t steps [12];
        steps[0]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'b0001_1010, 4'd1, 8'h5A};
        steps[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'b0011_0000, 4'd0, 8'h00};
        steps[2]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'b0001_1010, 4'd1, 8'h01};
        steps[3]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'b0000_1010, 4'd2, 8'h01};
        steps[4]  = '{1'b1, 1'b0, 1'b0, 8'h03, 8'b0000_1010, 4'd3, 8'h01};
        steps[5]  = '{1'b1, 1'b0, 1'b0, 8'h04, 8'b0000_1010, 4'd4, 8'h01};
        steps[6]  = '{1'b1, 1'b0, 1'b0, 8'h05, 8'b0000_1010, 4'd5, 8'h01};
        steps[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'b0000_0010, 4'd4, 8'h02};
        steps[8]  = '{1'b1, 1'b1, 1'b1, 8'hEE, 8'b0011_0000, 4'd0, 8'h00};
        steps[9]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'b0001_1010, 4'd1, 8'h33};
        steps[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'b0011_0000, 4'd0, 8'h00};
        steps[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'b0011_0001, 4'd0, 8'h00};
        for (int i = 0; i < 12; i++) begin
            f_wr_en = steps[i].wr;
            f_rd_en = steps[i].rd;
            f_rst   = steps[i].rst;
            f_din   = steps[i].din;
            @(posedge clk);
            #1;
            f_wr_en = 1'b0;
            f_rd_en = 1'b0;
            f_rst   = 1'b0;
            tests_run++;
            if (f_flags !== steps[i].flags || f_count !== steps[i].count || f_dout !== steps[i].dout) begin
                tests_failed++;
                $display("FAIL fwft_step[%0d]: flags=%b count=%0d dout=%h, expected flags=%b count=%0d dout=%h",
                         i, f_flags, f_count, f_dout, steps[i].flags, steps[i].count, steps[i].dout);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_std_fill();
        test_std_drain();
        test_simultaneous();
        test_wrap_random();
        test_fwft_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
